exu_muldiv: RTL and testbench



---
 rtl/exu_muldiv.sv | 170 +++++++++++++++++
 tb/tb_exu_muldiv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv.sv
// Multi-cycle RISC-V M-extension multiply/divide unit beside the ALU.
// Counted multiply, restoring radix-2 divide with optional early-out for divide special cases.
module exu_muldiv #(
    parameter int XLEN      = 32,
    parameter int MUL_LAT   = 3,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_src2,
    input  logic            ex_out_valid,
    input  logic            ex_flush,
    output logic [XLEN-1:0] ex_result,
    output logic [2:0]      ex_exception,
    output logic            ex_in_valid,
    output logic            ex_busy
);
    localparam int CW = $clog2(XLEN + 2);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q, quo_q, rem_q, result_q;
    logic [2:0]      exc_q;
    logic            valid_q, busy_q, dz_q, ovf_q, negq_q, negr_q;

    logic            start_ok, accept, drop, in_div, in_dz, in_ovf;
    logic            op_signed, neg_a, neg_b;
    logic [2*XLEN-1:0] ma, mb, prod;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_d, quo_d, res_d;

    // The result cycle is IDLE again, so a start there is a normal accept.
    assign start_ok = (state_q == S_IDLE) || valid_q;
    assign accept   = ex_out_valid && !ex_flush && start_ok;
    assign drop     = ex_out_valid && !ex_flush && !start_ok;
    assign in_div   = ex_op[2];
    assign in_dz    = in_div && (ex_src2 == '0);
    assign in_ovf   = in_div && !ex_op[0] && (ex_src1 == MIN_NEG) && (&ex_src2);

    assign op_signed = !op_q[0];
    assign neg_a     = op_signed && a_q[XLEN-1];
    assign neg_b     = op_signed && b_q[XLEN-1];

    always_comb begin
        ma   = {{XLEN{a_q[XLEN-1] & ((op_q == 3'd1) || (op_q == 3'd2))}}, a_q};
        mb   = {{XLEN{b_q[XLEN-1] & (op_q == 3'd1)}}, b_q};
        prod = ma * mb;
    end

    // One restoring step: b_q holds |divisor| once setup has run.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        res_d = '0;
        if (ovf_q)
            res_d = op_q[1] ? '0 : a_q;
        else if (dz_q)
            res_d = op_q[1] ? a_q : '1;
        else if (op_q[1])
            res_d = negr_q ? -rem_q : rem_q;
        else
            res_d = negq_q ? -quo_q : quo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            exc_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            if (ex_flush) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_MUL: begin
                        if (cnt_q == CW'(MUL_LAT - 1)) begin
                            result_q   <= (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                            exc_q[1:0] <= 2'b00;
                            valid_q    <= 1'b1;
                            state_q    <= S_IDLE;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q  <= cnt_q + CW'(1);
                            busy_q <= 1'b1;
                        end
                    end
                    S_DIV: begin
                        busy_q <= 1'b1;
                        if (cnt_q == '0) begin
                            quo_q  <= neg_a ? -a_q : a_q;
                            b_q    <= neg_b ? -b_q : b_q;
                            rem_q  <= '0;
                            negq_q <= neg_a ^ neg_b;
                            negr_q <= neg_a;
                        end else begin
                            quo_q <= quo_d;
                            rem_q <= rem_d;
                        end
                        if (cnt_q == CW'(XLEN)) begin
                            state_q <= S_FIX;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    S_FIX: begin
                        result_q   <= res_d;
                        exc_q[1:0] <= {ovf_q, dz_q};
                        valid_q    <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                    default: ;
                endcase
                if (accept) begin
                    op_q  <= ex_op;
                    a_q   <= ex_src1;
                    b_q   <= ex_src2;
                    dz_q  <= in_dz;
                    ovf_q <= in_ovf;
                    exc_q <= 3'b000;
                    cnt_q <= '0;
                    if (!in_div)
                        state_q <= S_MUL;
                    else if ((EARLY_OUT != 0) && (in_dz || in_ovf))
                        state_q <= S_FIX;
                    else
                        state_q <= S_DIV;
                end else if (drop) begin
                    exc_q[2] <= 1'b1;
                end
            end
        end
    end

    assign ex_result    = result_q;
    assign ex_exception = exc_q;
    assign ex_in_valid  = valid_q;
    assign ex_busy      = busy_q;
endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv: vector table plus hand sequences for flush, drop, back-to-back and reset.
module tb_exu_muldiv;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ex_flush, v0, v1;
    logic [2:0]  ex_op;
    logic [31:0] s1, s2;
    logic [31:0] r0, r1;
    logic [2:0]  e0, e1;
    logic        iv0, iv1, b0, b1;

    exu_muldiv #(.XLEN(32), .MUL_LAT(3), .EARLY_OUT(1)) dut0 (
        .clk(clk), .rst(rst), .ex_op(ex_op), .ex_src1(s1), .ex_src2(s2),
        .ex_out_valid(v0), .ex_flush(ex_flush), .ex_result(r0),
        .ex_exception(e0), .ex_in_valid(iv0), .ex_busy(b0));

    exu_muldiv #(.XLEN(32), .MUL_LAT(3), .EARLY_OUT(0)) dut1 (
        .clk(clk), .rst(rst), .ex_op(ex_op), .ex_src1(s1), .ex_src2(s2),
        .ex_out_valid(v1), .ex_flush(ex_flush), .ex_result(r1),
        .ex_exception(e1), .ex_in_valid(iv1), .ex_busy(b1));

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  exc;
        int          lat;
    } vec_t;

    vec_t vecs[18];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one op on dut0 (which=0) or dut1 (which=1), scribble inputs after the
    // accepting edge, then wait (bounded) for the result pulse.
    task automatic run_op(input bit which, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output logic [2:0] exc, output int lat, output int nbusy);
        @(negedge clk);
        ex_op = op; s1 = a; s2 = b;
        if (which) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        s1 = $urandom; s2 = $urandom; ex_op = 3'($urandom);
        lat = 0; nbusy = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (which ? b1 : b0) nbusy++;
            if (which ? iv1 : iv0) begin
                lat = k;
                break;
            end
        end
        res = which ? r1 : r0;
        exc = which ? e1 : e0;
    endtask

    initial begin
        logic [31:0] res;
        logic [2:0]  exc;
        int          lat, nbusy;
        bit          saw;

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 3'b000, 3};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3'b000, 3};
        vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b000, 3};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 3};
        vecs[4]  = '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 3'b000, 3};
        vecs[5]  = '{3'd3, 32'h80000000, 32'h00000004, 32'h00000002, 3'b000, 3};
        vecs[6]  = '{3'd1, 32'h80000000, 32'h00000004, 32'hFFFFFFFE, 3'b000, 3};
        vecs[7]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 3'b000, 34};
        vecs[8]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 3'b000, 34};
        vecs[9]  = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 3'b000, 34};
        vecs[10] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 3'b000, 34};
        vecs[11] = '{3'd5, 32'd100,      32'd7,        32'd14,       3'b000, 34};
        vecs[12] = '{3'd7, 32'd100,      32'd7,        32'd2,        3'b000, 34};
        vecs[13] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 3'b000, 34};
        vecs[14] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 3'b001, 1};
        vecs[15] = '{3'd7, 32'd5,        32'd0,        32'd5,        3'b001, 1};
        vecs[16] = '{3'd6, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 3'b001, 1};
        vecs[17] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 3'b010, 1};

        rst = 1'b1; ex_flush = 1'b0; v0 = 1'b0; v1 = 1'b0;
        ex_op = 3'd4; s1 = 32'd9; s2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 64'(r0), 64'd0);
        chk("rst_exc",    64'(e0), 64'd0);
        chk("rst_valid",  64'(iv0), 64'd0);
        chk("rst_busy",   64'(b0), 64'd0);
        chk("rst_result1", 64'(r1), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, res, exc, lat, nbusy);
            chk($sformatf("vec%0d_result", i),  64'(res), 64'(vecs[i].res));
            chk($sformatf("vec%0d_exc", i),     64'(exc), 64'(vecs[i].exc));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'(vecs[i].lat - 1));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse_width", i), 64'(iv0), 64'd0);
        end

        // Without early-out a divide by zero takes the full divide latency.
        run_op(1'b1, 3'd5, 32'd5, 32'd0, res, exc, lat, nbusy);
        chk("noeo_result",  64'(res), 64'hFFFFFFFF);
        chk("noeo_exc",     64'(exc), 64'b001);
        chk("noeo_latency", 64'(lat), 64'd34);

        // Start while busy is dropped and flagged; the running divide is unaffected.
        @(negedge clk);
        ex_op = 3'd5; s1 = 32'd100; s2 = 32'd7; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 3) begin
                ex_op = 3'd0; s1 = 32'd3; s2 = 32'd3; v0 = 1'b1;
            end
            @(posedge clk); #1;
            v0 = 1'b0;
            if (k == 3) chk("drop_sticky", 64'(e0[2]), 64'd1);
            if (iv0) begin
                lat = k;
                break;
            end
        end
        chk("drop_latency", 64'(lat), 64'd34);
        chk("drop_result",  64'(r0), 64'd14);
        chk("drop_exc",     64'(e0), 64'b100);

        // Back-to-back: issue in the result cycle of a divide.
        @(negedge clk);
        ex_op = 3'd4; s1 = 32'hFFFFFFF9; s2 = 32'd2; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (iv0) begin
                lat = k;
                break;
            end
        end
        chk("b2b_div_latency", 64'(lat), 64'd34);
        chk("b2b_div_result",  64'(r0), 64'hFFFFFFFD);
        ex_op = 3'd3; s1 = 32'hFFFFFFFF; s2 = 32'hFFFFFFFF; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        chk("b2b_no_drop", 64'(e0), 64'b000);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (iv0) begin
                lat = k;
                break;
            end
        end
        chk("b2b_mul_latency", 64'(lat), 64'd3);
        chk("b2b_mul_result",  64'(r0), 64'hFFFFFFFE);
        chk("b2b_mul_exc",     64'(e0), 64'b000);

        // Flush together with start: start ignored, no drop flag.
        @(negedge clk);
        ex_flush = 1'b1; v0 = 1'b1; ex_op = 3'd0; s1 = 32'd2; s2 = 32'd3;
        @(posedge clk); #1;
        ex_flush = 1'b0; v0 = 1'b0;
        chk("flushstart_exc", 64'(e0), 64'b000);
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (iv0 || b0) saw = 1'b1;
        end
        chk("flushstart_idle", 64'(saw), 64'd0);

        // Flush at edge 10 of a divide: no pulse ever, outputs held.
        @(negedge clk);
        ex_op = 3'd5; s1 = 32'd100; s2 = 32'd7; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("flush_busy_before", 64'(b0), 64'd1);
        @(negedge clk);
        ex_flush = 1'b1;
        @(posedge clk); #1;
        ex_flush = 1'b0;
        @(posedge clk); #1;
        chk("flush_busy_after", 64'(b0), 64'd0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (iv0) saw = 1'b1;
        end
        chk("flush_no_pulse",  64'(saw), 64'd0);
        chk("flush_result_kept", 64'(r0), 64'hFFFFFFFE);
        chk("flush_exc_kept",  64'(e0), 64'b000);

        // Reset mid-operation discards it silently.
        @(negedge clk);
        ex_op = 3'd4; s1 = 32'd50; s2 = 32'd5; v0 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_result", 64'(r0), 64'd0);
        chk("midrst_busy",   64'(b0), 64'd0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (iv0) saw = 1'b1;
        end
        chk("midrst_no_pulse", 64'(saw), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
